// File: rtl/risc_pkg.sv
// Shared types and constants for the memory-side blocks.
// Imported by the arbiter and its round-robin picker.
package risc_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: rr selects the preferred port on a tie.
// Purely combinational; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       gnt_id,
    output logic       any
);
    import risc_pkg::*;

    always_comb begin
        gnt_id = PORT_CPU;
        unique case (req)
            2'b11:   gnt_id = rr;
            2'b10:   gnt_id = PORT_DBG;
            default: gnt_id = PORT_CPU;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported program/data memory between the core and the
// debug loader with fixed IDLE/ACCESS/DONE sequencing and one bus owner.
module mem_arbiter #(
    parameter int ADDR_W = risc_pkg::ADDR_W,
    parameter int DATA_W = risc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);
    import risc_pkg::*;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              rr;
    logic              gnt_id;
    logic              any;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        ack_q;
    logic              drive;

    rr_arb2 u_pick (
        .req    (req),
        .rr     (rr),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = any ? ACCESS : IDLE;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        drive  = 1'b0;
        if (state == ACCESS) begin
            mem_rd = !we_q;
            mem_wr = we_q;
            drive  = we_q;
        end
    end

    // addr_q doubles as mem_addr, so it holds between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr      <= PORT_CPU;
            id_q    <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        id_q    <= gnt_id;
                        we_q    <= we[gnt_id];
                        addr_q  <= gnt_id ? addr1 : addr0;
                        wdata_q <= gnt_id ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    if (!we_q) rdata_q <= mem_data;
                    ack_q[id_q] <= 1'b1;
                end
                DONE: rr <= ~id_q;
                default: ;
            endcase
        end
    end

    assign mem_data = drive ? wdata_q : {DATA_W{1'bz}};
    assign mem_addr = addr_q;
    assign rdata    = rdata_q;
    assign ack      = ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a simple 32x8 memory model
// and a transaction-level reference model for randomized traffic.
module tb_mem_arbiter;
    import risc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    wire  [DATA_W-1:0] mem_data;

    logic [DATA_W-1:0] mem [32];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_a = '0;
    logic [DATA_W-1:0] pre_d = '0;
    logic [DATA_W-1:0] zz = {DATA_W{1'bz}};

    int tests = 0;
    int failed = 0;
    int rd_cnt, wr_cnt;
    logic [1:0] ack_seen;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack      (ack),
        .rdata    (rdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_rd ? mem[mem_addr] : {DATA_W{1'bz}};

    always @(posedge clk) begin
        if (mem_wr)      mem[mem_addr] <= mem_data;
        else if (pre_en) mem[pre_a] <= pre_d;
    end

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        pre_a = a;
        pre_d = d;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        req = '0; we = '0;
        addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic w,
                         input logic [4:0] a, input logic [7:0] d);
        req[p] = 1'b1;
        we[p] = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else begin addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_ack(input int p, output int cyc);
        cyc = -1;
        rd_cnt = 0;
        wr_cnt = 0;
        ack_seen = '0;
        for (int i = 1; i <= 10 && cyc < 0; i++) begin
            @(negedge clk);
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            if (ack[p]) begin
                cyc = i;
                ack_seen = ack;
                req[p] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (ack !== 2'b00) begin failed++;
            $display("FAIL reset_ack got=%b exp=00", ack); end
        tests++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failed++;
            $display("FAIL reset_strobes got=%b%b exp=00", mem_rd, mem_wr); end
        tests++; if (mem_addr !== 5'h00) begin failed++;
            $display("FAIL reset_addr got=%h exp=00", mem_addr); end
        tests++; if (rdata !== 8'h00) begin failed++;
            $display("FAIL reset_rdata got=%h exp=00", rdata); end
        tests++; if (mem_data !== zz) begin failed++;
            $display("FAIL reset_bus got=%h exp=zz", mem_data); end
    endtask

    task automatic test_single_read();
        int cyc;
        poke(5'h03, 8'hA5);
        drive(0, 1'b0, 5'h03, 8'h00);
        wait_ack(0, cyc);
        tests++; if (cyc != 2 || ack_seen !== 2'b01) begin failed++;
            $display("FAIL rd_ack cyc=%0d ack=%b exp cyc=2 ack=01", cyc, ack_seen); end
        tests++; if (rdata !== 8'hA5) begin failed++;
            $display("FAIL rd_data got=%h exp=a5", rdata); end
        tests++; if (rd_cnt != 1 || wr_cnt != 0) begin failed++;
            $display("FAIL rd_strobe rd=%0d wr=%0d exp rd=1 wr=0", rd_cnt, wr_cnt); end
        @(negedge clk);
    endtask

    task automatic test_write_readback();
        int cyc;
        drive(1, 1'b1, 5'h1F, 8'h3C);
        wait_ack(1, cyc);
        tests++; if (cyc != 2 || ack_seen !== 2'b10) begin failed++;
            $display("FAIL wr_ack cyc=%0d ack=%b exp cyc=2 ack=10", cyc, ack_seen); end
        tests++; if (mem_data !== zz) begin failed++;
            $display("FAIL wr_turnaround got=%h exp=zz", mem_data); end
        tests++; if (wr_cnt != 1 || rd_cnt != 0) begin failed++;
            $display("FAIL wr_strobe rd=%0d wr=%0d exp rd=0 wr=1", rd_cnt, wr_cnt); end
        @(negedge clk);
        drive(1, 1'b0, 5'h1F, 8'h00);
        wait_ack(1, cyc);
        tests++; if (cyc != 2 || ack_seen !== 2'b10) begin failed++;
            $display("FAIL rb_ack cyc=%0d ack=%b exp cyc=2 ack=10", cyc, ack_seen); end
        tests++; if (rdata !== 8'h3C) begin failed++;
            $display("FAIL rb_data got=%h exp=3c", rdata); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int a0_first = -1;
        int a0_second = -1;
        int a1 = -1;
        do_reset();
        drive(0, 1'b0, 5'h00, 8'h00);
        drive(1, 1'b1, 5'h01, 8'h11);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack[1]) begin
                if (a1 < 0) a1 = i;
                req[1] = 1'b0;
            end
            // port 0 keeps req high after its first ack: a fresh request
            if (ack[0]) begin
                if (a0_first < 0) a0_first = i;
                else begin a0_second = i; req[0] = 1'b0; end
            end
        end
        tests++; if (a0_first != 2) begin failed++;
            $display("FAIL cont_p0_first got=%0d exp=2", a0_first); end
        tests++; if (a1 != 5) begin failed++;
            $display("FAIL cont_p1 got=%0d exp=5", a1); end
        tests++; if (a0_second != 8) begin failed++;
            $display("FAIL cont_p0_second got=%0d exp=8", a0_second); end
        tests++; if (mem[1] !== 8'h11) begin failed++;
            $display("FAIL cont_wr got=%h exp=11", mem[1]); end
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [8];
        logic [1:0] exp_seq [4];
        int n = 0;
        int both = 0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        do_reset();
        drive(0, 1'b0, 5'($urandom_range(0, 31)), 8'h00);
        drive(1, 1'b1, 5'($urandom_range(0, 31)), 8'($urandom));
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) both++;
            if (ack != 2'b00 && n < 8) begin seq[n] = ack; n++; end
            if (i == 12) req = '0;
        end
        tests++; if (n != 4) begin failed++;
            $display("FAIL b2b_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (k >= n || seq[k] !== exp_seq[k]) begin failed++;
                $display("FAIL b2b_seq%0d got=%b exp=%b", k,
                         (k < n) ? seq[k] : 2'bxx, exp_seq[k]); end
        end
        tests++; if (both != 0) begin failed++;
            $display("FAIL b2b_overlap got=%0d exp=0", both); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int acks = 0;
        poke(5'h05, 8'h6B);
        drive(1, 1'b1, 5'h05, 8'h77);
        @(negedge clk);
        tests++; if (mem_wr !== 1'b1) begin failed++;
            $display("FAIL rst_mid_access got=%b exp=1", mem_wr); end
        rst_n = 1'b0;
        #1;
        tests++; if (ack !== 2'b00 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failed++;
            $display("FAIL rst_mid_ctl ack=%b rd=%b wr=%b exp 00/0/0", ack, mem_rd, mem_wr); end
        tests++; if (mem_addr !== 5'h00 || rdata !== 8'h00) begin failed++;
            $display("FAIL rst_mid_regs addr=%h rdata=%h exp 00/00", mem_addr, rdata); end
        tests++; if (mem_data !== zz) begin failed++;
            $display("FAIL rst_mid_bus got=%h exp=zz", mem_data); end
        req = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (ack != 2'b00) acks++;
        tests++; if (acks != 0) begin failed++;
            $display("FAIL rst_mid_noack got=%0d exp=0", acks); end
        drive(1, 1'b0, 5'h05, 8'h00);
        wait_ack(1, cyc);
        tests++; if (cyc != 2 || rdata !== 8'h6B) begin failed++;
            $display("FAIL rst_mid_read cyc=%0d rdata=%h exp 2/6b", cyc, rdata); end
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int extra = 0;
        poke(5'h07, 8'h5A);
        drive(0, 1'b0, 5'h07, 8'h00);
        @(negedge clk);
        tests++; if (mem_rd !== 1'b1) begin failed++;
            $display("FAIL drop_access got=%b exp=1", mem_rd); end
        req[0] = 1'b0;
        @(negedge clk);
        tests++; if (ack !== 2'b01 || rdata !== 8'h5A) begin failed++;
            $display("FAIL drop_ack ack=%b rdata=%h exp 01/5a", ack, rdata); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack != 2'b00 || mem_rd || mem_wr) extra++;
        end
        tests++; if (extra != 0) begin failed++;
            $display("FAIL drop_regrant got=%0d exp=0", extra); end
    endtask

    // Transaction-level model: a grant every 3 cycles at most, ack 2 edges
    // after the sampling edge, preference flips to the port not served.
    task automatic test_random();
        logic [7:0] shadow [32];
        int         free_at = 0;
        logic       ptr = 1'b0;
        logic       pend = 1'b0;
        int         ack_edge = -10;
        logic       pport = 1'b0;
        logic       pwe = 1'b0;
        logic [7:0] prd = '0;
        logic [7:0] exp_rdata = '0;
        logic [1:0] exp_ack;
        logic       win;
        logic [4:0] a;
        int         errs = 0;
        int         overlap = 0;
        int         nack = 0;
        do_reset();
        for (int k = 0; k < 32; k++) shadow[k] = mem[k];
        for (int i = 0; i < 400; i++) begin
            if (i > 0) @(negedge clk);
            exp_ack = 2'b00;
            if (pend && ack_edge == i - 1) begin
                exp_ack = 2'b01 << pport;
                if (!pwe) exp_rdata = prd;
                pend = 1'b0;
                nack++;
            end
            tests++; if (ack !== exp_ack) begin failed++;
                if (errs++ < 10) $display("FAIL rnd_ack t=%0d got=%b exp=%b", i, ack, exp_ack); end
            tests++; if (rdata !== exp_rdata) begin failed++;
                if (errs++ < 10) $display("FAIL rnd_rdata t=%0d got=%h exp=%h", i, rdata, exp_rdata); end
            if (mem_rd && mem_wr) overlap++;
            for (int p = 0; p < 2; p++) begin
                if (exp_ack[p]) req[p] = 1'b0;
                else if (!req[p] && $urandom_range(0, 9) < 4)
                    drive(p, 1'($urandom), 5'($urandom), 8'($urandom));
            end
            if (i >= free_at && req != 2'b00) begin
                win = (req == 2'b11) ? ptr : req[1];
                pend = 1'b1;
                pport = win;
                ack_edge = i + 1;
                free_at = i + 3;
                ptr = ~win;
                a = win ? addr1 : addr0;
                pwe = we[win];
                if (pwe) shadow[a] = win ? wdata1 : wdata0;
                else prd = shadow[a];
            end
        end
        req = '0;
        tests++; if (overlap != 0) begin failed++;
            $display("FAIL rnd_overlap got=%0d exp=0", overlap); end
        tests++; if (nack < 20) begin failed++;
            $display("FAIL rnd_activity got=%0d exp>=20", nack); end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0;
        addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 32; i++) poke(5'(i), 8'(i * 13 + 7));
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_early_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
